// File: rtl/bitwise_result_checker.sv
// Checks one op/operand/result vector at a time against a golden AND/OR/XOR/NOT
// result and keeps saturating pass/fail counters plus a first-mismatch capture.
module bitwise_result_checker #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [SIZE-1:0]  in1,
  input  logic [SIZE-1:0]  in2,
  input  logic [SIZE-1:0]  dut_out,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic [1:0]       err_op,
  output logic [SIZE-1:0]  err_in1,
  output logic [SIZE-1:0]  err_in2,
  output logic [SIZE-1:0]  err_dut,
  output logic [SIZE-1:0]  err_exp
);

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [SIZE-1:0] r_in1;
  logic [SIZE-1:0] r_in2;
  logic [SIZE-1:0] r_dut;
  logic [SIZE-1:0] r_exp;
  logic [SIZE-1:0] w_gold;
  logic            w_clr;
  logic            w_match;

  assign w_clr    = rst | clear;
  assign in_ready = (r_state == IDLE) && !w_clr;
  assign w_match  = (r_exp == r_dut);

  always_comb begin
    w_gold = '0;
    unique case (r_op)
      2'b00:   w_gold = r_in1 & r_in2;
      2'b01:   w_gold = r_in1 | r_in2;
      2'b10:   w_gold = r_in1 ^ r_in2;
      default: w_gold = ~r_in1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_dut     <= '0;
      r_exp     <= '0;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_flag  <= 1'b0;
      err_op    <= '0;
      err_in1   <= '0;
      err_in2   <= '0;
      err_dut   <= '0;
      err_exp   <= '0;
    end else begin
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_in1   <= in1;
            r_in2   <= in2;
            r_dut   <= dut_out;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_exp   <= w_gold;
          r_state <= UPDATE;
        end
        UPDATE: begin
          res_valid <= 1'b1;
          res_pass  <= w_match;
          if (w_match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            // Only the first mismatch since rst/clear is kept.
            if (!err_flag) begin
              err_flag <= 1'b1;
              err_op   <= r_op;
              err_in1  <= r_in1;
              err_in2  <= r_in2;
              err_dut  <= r_dut;
              err_exp  <= r_exp;
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_result_checker.sv
// Bench for bitwise_result_checker: two instances (CNT_W=16 and CNT_W=2) share
// stimulus and are checked every cycle against a countdown-based reference model.
module tb_bitwise_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] op = '0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic [7:0] dut_out = '0;

  logic        a_ready, a_rv, a_rp, a_eflag;
  logic [15:0] a_pcnt, a_fcnt;
  logic [1:0]  a_eop;
  logic [7:0]  a_ein1, a_ein2, a_edut, a_eexp;
  logic        b_ready, b_rv, b_rp, b_eflag;
  logic [1:0]  b_pcnt, b_fcnt;
  logic [1:0]  b_eop;
  logic [7:0]  b_ein1, b_ein2, b_edut, b_eexp;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  bitwise_result_checker #(.SIZE(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_ready),
    .op(op), .in1(in1), .in2(in2), .dut_out(dut_out),
    .res_valid(a_rv), .res_pass(a_rp), .pass_cnt(a_pcnt), .fail_cnt(a_fcnt),
    .err_flag(a_eflag), .err_op(a_eop), .err_in1(a_ein1), .err_in2(a_ein2),
    .err_dut(a_edut), .err_exp(a_eexp)
  );

  bitwise_result_checker #(.SIZE(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_ready),
    .op(op), .in1(in1), .in2(in2), .dut_out(dut_out),
    .res_valid(b_rv), .res_pass(b_rp), .pass_cnt(b_pcnt), .fail_cnt(b_fcnt),
    .err_flag(b_eflag), .err_op(b_eop), .err_in1(b_ein1), .err_in2(b_ein2),
    .err_dut(b_edut), .err_exp(b_eexp)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] gold(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Reference model: a vector accepted at an edge produces its result two edges later.
  int         pend = 0;
  logic [1:0] p_op;
  logic [7:0] p_in1, p_in2, p_dut, p_exp;
  int         m_pass = 0, m_fail = 0;
  bit         m_rv = 0, m_rp = 0, m_err = 0;
  logic [1:0] m_eop = '0;
  logic [7:0] m_ein1 = '0, m_ein2 = '0, m_edut = '0, m_eexp = '0;

  always @(posedge clk) begin
    if (rst || clear) begin
      pend = 0; m_pass = 0; m_fail = 0; m_rv = 0; m_rp = 0; m_err = 0;
      m_eop = '0; m_ein1 = '0; m_ein2 = '0; m_edut = '0; m_eexp = '0;
    end else begin
      m_rv = 0;
      if (pend == 0) begin
        if (in_valid) begin
          p_op = op; p_in1 = in1; p_in2 = in2; p_dut = dut_out; pend = 2;
        end
      end else begin
        pend--;
        if (pend == 0) begin
          p_exp = gold(p_op, p_in1, p_in2);
          m_rv  = 1;
          m_rp  = (p_exp == p_dut);
          if (m_rp) m_pass++;
          else begin
            m_fail++;
            if (!m_err) begin
              m_err = 1; m_eop = p_op; m_ein1 = p_in1; m_ein2 = p_in2;
              m_edut = p_dut; m_eexp = p_exp;
            end
          end
        end
      end
    end
  end

  int rv_cnt = 0;
  bit last_pass = 0;

  always @(negedge clk) begin
    bit er;
    er = (pend == 0) && !rst && !clear;
    chk("a_in_ready", a_ready, er);
    chk("b_in_ready", b_ready, er);
    chk("a_res_valid", a_rv, m_rv);
    chk("b_res_valid", b_rv, m_rv);
    if (m_rv) begin
      chk("a_res_pass", a_rp, m_rp);
      chk("b_res_pass", b_rp, m_rp);
    end
    chk("a_pass_cnt", a_pcnt, (m_pass > 65535) ? 65535 : m_pass);
    chk("a_fail_cnt", a_fcnt, (m_fail > 65535) ? 65535 : m_fail);
    chk("b_pass_cnt", b_pcnt, (m_pass > 3) ? 3 : m_pass);
    chk("b_fail_cnt", b_fcnt, (m_fail > 3) ? 3 : m_fail);
    chk("a_err", {a_eflag, a_eop, a_ein1, a_ein2, a_edut}, {m_err, m_eop, m_ein1, m_ein2, m_edut});
    chk("b_err", {b_eflag, b_eop, b_ein1, b_ein2, b_edut}, {m_err, m_eop, m_ein1, m_ein2, m_edut});
    chk("a_err_exp", a_eexp, m_eexp);
    chk("b_err_exp", b_eexp, m_eexp);
    if (a_rv) begin
      rv_cnt++;
      last_pass = a_rp;
    end
  end

  // kind: 0 normal, 1 clear during CALC, 2 rst during UPDATE
  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] d, input int kind);
    bit got;
    got = 0;
    op = o; in1 = x; in2 = y; dut_out = d; in_valid = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
    if (kind == 1) begin
      clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    end else if (kind == 2) begin
      @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int rv0;
    int acc;
    int acc_k[$];
    logic [7:0] bv_in1[3];
    logic [7:0] bv_in2[3];
    logic [7:0] bv_dut[3];
    logic [1:0] bv_op[3];

    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_pass", a_pcnt, 0);
    chk("lit_reset_flag", a_eflag, 0);
    chk("lit_reset_ready", a_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(2'b01, 8'b10101010, 8'b11001100, 8'b11101110, 0);
    chk("lit_t1_pass_cnt", a_pcnt, 1);
    chk("lit_t1_fail_cnt", a_fcnt, 0);
    chk("lit_t1_flag", a_eflag, 0);
    chk("lit_t1_res_pass", last_pass, 1);
    chk("lit_t1_model", m_pass, 1);

    send(2'b01, 8'b11111111, 8'b00000000, 8'b11111110, 0);
    chk("lit_t2_res_pass", last_pass, 0);
    chk("lit_t2_fail_cnt", a_fcnt, 1);
    chk("lit_t2_flag", a_eflag, 1);
    chk("lit_t2_err_exp", a_eexp, 8'b11111111);
    chk("lit_t2_err_dut", a_edut, 8'b11111110);

    send(2'b00, 8'hF0, 8'h0F, 8'h01, 0);
    chk("lit_t3_fail_cnt", a_fcnt, 2);
    chk("lit_t3_err_op", a_eop, 2'b01);
    chk("lit_t3_err_in1", a_ein1, 8'hFF);
    chk("lit_t3_err_exp", a_eexp, 8'hFF);
    chk("lit_t3_b_fail", b_fcnt, 2);

    // Back-to-back: in_valid high for 9 cycles, vector k/3 presented in cycle k.
    bv_op[0] = 2'b00; bv_in1[0] = 8'h3C; bv_in2[0] = 8'h0F; bv_dut[0] = 8'h0C;
    bv_op[1] = 2'b10; bv_in1[1] = 8'h3C; bv_in2[1] = 8'h0F; bv_dut[1] = 8'h33;
    bv_op[2] = 2'b11; bv_in1[2] = 8'h3C; bv_in2[2] = 8'hAA; bv_dut[2] = 8'hC3;
    acc = 0;
    rv0 = rv_cnt;
    for (int k = 0; k < 9; k++) begin
      op = bv_op[k/3]; in1 = bv_in1[k/3]; in2 = bv_in2[k/3]; dut_out = bv_dut[k/3];
      in_valid = 1'b1;
      @(negedge clk);
      if (a_ready) begin acc++; acc_k.push_back(k); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("lit_b2b_accepts", acc, 3);
    if (acc_k.size() == 3) begin
      chk("lit_b2b_gap1", acc_k[1] - acc_k[0], 3);
      chk("lit_b2b_gap2", acc_k[2] - acc_k[1], 3);
    end
    chk("lit_b2b_pass_cnt", a_pcnt, 4);
    chk("lit_b2b_pulses", rv_cnt - rv0, 3);

    // Saturation on the CNT_W=2 instance after a soft clear.
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    rv0 = rv_cnt;
    for (int i = 0; i < 5; i++) send(2'b10, 8'h55, 8'hAA, 8'hFF, 0);
    chk("lit_sat_b_pass", b_pcnt, 3);
    chk("lit_sat_a_pass", a_pcnt, 5);
    chk("lit_sat_pulses", rv_cnt - rv0, 5);

    // clear together with in_valid: nothing accepted.
    op = 2'b00; in1 = 8'hFF; in2 = 8'hFF; dut_out = 8'h00;
    in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk("lit_clr_ready", a_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    rv0 = rv_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("lit_clr_nopulse", rv_cnt - rv0, 0);

    rv0 = rv_cnt;
    send(2'b00, 8'hFF, 8'h0F, 8'h00, 1);
    chk("lit_abort_clr_pulses", rv_cnt - rv0, 0);
    chk("lit_abort_clr_fail", a_fcnt, 0);
    chk("lit_abort_clr_flag", a_eflag, 0);
    send(2'b01, 8'h01, 8'h02, 8'h03, 0);
    chk("lit_abort_clr_next", a_pcnt, 1);

    rv0 = rv_cnt;
    send(2'b10, 8'hFF, 8'h0F, 8'h00, 2);
    chk("lit_abort_rst_pulses", rv_cnt - rv0, 0);
    chk("lit_abort_rst_fail", a_fcnt, 0);
    chk("lit_abort_rst_pass", a_pcnt, 0);
    chk("lit_abort_rst_flag", a_eflag, 0);
    send(2'b11, 8'h5A, 8'h00, 8'hA5, 0);
    chk("lit_abort_rst_next", a_pcnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
